// File: rtl/byte_lane_packer.sv
// Packs a stream of DW-bit bytes into LANES-wide words with early close on in_last.
// A complete word waits in the accumulator (STALL) while the output register is occupied.
module byte_lane_packer #(
  parameter int LANES = 12,
  parameter int DW    = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DW-1:0]              in_data,
  input  logic                       in_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [LANES-1:0][DW-1:0]   out_data,
  output logic [$clog2(LANES+1)-1:0] out_count,
  output logic                       out_last,
  output logic [15:0]                word_cnt
);

  localparam int IW = $clog2(LANES);
  localparam int CW = $clog2(LANES + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(LANES - 1);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FILL  = 2'd1,
    ST_STALL = 2'd2
  } state_t;

  state_t                   state_r, state_nxt_s;
  logic [IW-1:0]            lane_idx_r, lane_idx_nxt_s;
  logic [LANES-1:0][DW-1:0] acc_r, acc_nxt_s, merged_s;
  logic [CW-1:0]            pend_count_r, pend_count_nxt_s;
  logic                     pend_last_r, pend_last_nxt_s;
  logic                     out_valid_r, out_last_r;
  logic [LANES-1:0][DW-1:0] out_data_r;
  logic [CW-1:0]            out_count_r;
  logic [15:0]              word_cnt_r;
  logic                     in_ready_s, in_xfer_s, out_xfer_s, out_free_s, complete_s;
  logic                     load_s, load_last_s;
  logic [LANES-1:0][DW-1:0] load_data_s;
  logic [CW-1:0]            cur_count_s;

  assign in_ready_s  = (state_r != ST_STALL);
  assign in_xfer_s   = in_valid & in_ready_s;
  assign out_xfer_s  = out_valid_r & out_ready;
  assign out_free_s  = ~out_valid_r | out_ready;
  assign complete_s  = in_xfer_s & ((lane_idx_r == LAST_IDX) | in_last);
  assign cur_count_s = CW'(lane_idx_r) + CW'(1'b1);

  // Accumulator with the offered byte dropped into the current lane.
  always_comb begin
    merged_s             = acc_r;
    merged_s[lane_idx_r] = in_data;
  end

  // Next-state, accumulator and output-load decisions.
  always_comb begin
    state_nxt_s      = state_r;
    lane_idx_nxt_s   = lane_idx_r;
    acc_nxt_s        = acc_r;
    pend_count_nxt_s = pend_count_r;
    pend_last_nxt_s  = pend_last_r;
    load_s           = 1'b0;
    load_data_s      = merged_s;
    load_count_s_def: begin end
    load_last_s      = in_last;
    case (state_r)
      ST_EMPTY, ST_FILL: begin
        if (complete_s) begin
          lane_idx_nxt_s = {IW{1'b0}};
          if (out_free_s) begin
            load_s      = 1'b1;
            acc_nxt_s   = '0;
            state_nxt_s = ST_EMPTY;
          end else begin
            acc_nxt_s        = merged_s;
            pend_count_nxt_s = cur_count_s;
            pend_last_nxt_s  = in_last;
            state_nxt_s      = ST_STALL;
          end
        end else if (in_xfer_s) begin
          acc_nxt_s      = merged_s;
          lane_idx_nxt_s = lane_idx_r + IW'(1'b1);
          state_nxt_s    = ST_FILL;
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_STALL: begin
        if (out_xfer_s) begin
          load_s      = 1'b1;
          load_data_s = acc_r;
          load_last_s = pend_last_r;
          acc_nxt_s   = '0;
          state_nxt_s = ST_EMPTY;
        end else begin
          state_nxt_s = ST_STALL;
        end
      end
      default: begin
        state_nxt_s    = ST_EMPTY;
        lane_idx_nxt_s = {IW{1'b0}};
        acc_nxt_s      = '0;
      end
    endcase
  end

  // A held word carries its own count; a fresh word uses the live lane index.
  logic [CW-1:0] load_count_s;
  assign load_count_s = (state_r == ST_STALL) ? pend_count_r : cur_count_s;

  // Packing state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_EMPTY;
      lane_idx_r   <= {IW{1'b0}};
      acc_r        <= '0;
      pend_count_r <= {CW{1'b0}};
      pend_last_r  <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      lane_idx_r   <= lane_idx_nxt_s;
      acc_r        <= acc_nxt_s;
      pend_count_r <= pend_count_nxt_s;
      pend_last_r  <= pend_last_nxt_s;
    end
  end

  // Output register and delivered-word counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_count_r <= {CW{1'b0}};
      out_last_r  <= 1'b0;
      word_cnt_r  <= 16'd0;
    end else begin
      if (load_s) begin
        out_valid_r <= 1'b1;
        out_data_r  <= load_data_s;
        out_count_r <= load_count_s;
        out_last_r  <= load_last_s;
      end else if (out_xfer_s) begin
        out_valid_r <= 1'b0;
      end else begin
        out_valid_r <= out_valid_r;
      end
      if (out_xfer_s) begin
        word_cnt_r <= word_cnt_r + 16'd1;
      end else begin
        word_cnt_r <= word_cnt_r;
      end
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_count = out_count_r;
  assign out_last  = out_last_r;
  assign word_cnt  = word_cnt_r;

endmodule

// File: tb/tb_byte_lane_packer.sv
// Scoreboard bench for byte_lane_packer: a queue-of-bytes model builds expected words,
// a negedge monitor compares every presented word and the ready/valid/count invariants.
module tb_byte_lane_packer;
  localparam int LANES = 12;
  localparam int DW    = 8;
  localparam int CW    = $clog2(LANES + 1);

  typedef logic [LANES-1:0][DW-1:0] word_t;
  typedef struct {
    word_t data;
    int    count;
    bit    last;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n, in_valid, in_ready, in_last, out_valid, out_last;
  logic          out_ready = 1'b0;
  logic [DW-1:0] in_data;
  word_t         out_data;
  logic [CW-1:0] out_count;
  logic [15:0]   word_cnt;

  int            n_checks = 0;
  int            n_errors = 0;
  int            cyc = 0;
  exp_t          exp_q[$];
  logic [DW-1:0] cur_q[$];
  logic [15:0]   delivered = 16'd0;
  bit            rand_mode = 1'b0;
  logic          fixed_rdy = 1'b0;

  byte_lane_packer #(.LANES(LANES), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_count(out_count), .out_last(out_last), .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Consumer readiness: fixed level or random back-pressure.
  always begin
    @(posedge clk);
    #2;
    out_ready = rand_mode ? 1'($urandom_range(0, 2) != 0) : fixed_rdy;
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: words in flight = completed - delivered; at most two fit in the block.
  always @(negedge clk) begin
    if (!rst_n) begin
      delivered = 16'd0;
    end else begin
      check("word_cnt", 128'(word_cnt), 128'(delivered));
      check("out_valid", 128'(out_valid), 128'(exp_q.size() != 0));
      check("in_ready", 128'(in_ready), 128'(exp_q.size() < 2));
      if (out_valid && exp_q.size() != 0) begin
        check("out_data", 128'(out_data), 128'(exp_q[0].data));
        check("out_count", 128'(out_count), 128'(exp_q[0].count));
        check("out_last", 128'(out_last), 128'(exp_q[0].last));
        if (out_ready) begin
          void'(exp_q.pop_front());
          delivered = delivered + 16'd1;
        end
      end
    end
  end

  task automatic send_byte(input logic [DW-1:0] d, input bit last);
    int   waited = 0;
    exp_t e;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    @(negedge clk);
    while (!in_ready && waited < 1000) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) begin
      check("accept_timeout", 128'(in_ready), 128'(1'b1));
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'($urandom);
    in_data  = DW'($urandom);
    cur_q.push_back(d);
    if (cur_q.size() == LANES || last) begin
      e.data = '0;
      for (int i = 0; i < cur_q.size(); i++) e.data[i] = cur_q[i];
      e.count = cur_q.size();
      e.last  = last;
      exp_q.push_back(e);
      cur_q.delete();
    end
  endtask

  task automatic drain();
    int w = 0;
    while (exp_q.size() != 0 && w < 2000) begin
      @(posedge clk);
      #1;
      w++;
    end
    check("drain_timeout", 128'(exp_q.size()), 128'(0));
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    cur_q.delete();
    repeat (2) @(negedge clk);
    check("rst_out_valid", 128'(out_valid), 128'(1'b0));
    check("rst_out_count", 128'(out_count), 128'(0));
    check("rst_out_last", 128'(out_last), 128'(1'b0));
    check("rst_out_data", 128'(out_data), 128'(0));
    check("rst_word_cnt", 128'(word_cnt), 128'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rst_in_ready", 128'(in_ready), 128'(1'b1));
  endtask

  initial begin
    #(95000 * 10);
    $display("FAIL watchdog: cycle %0d exceeded budget of 95000", cyc);
    $fatal(1);
  end

  initial begin
    int t0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // Full word, back to back, consumer always ready.
    fixed_rdy = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 1; i <= 12; i++) begin
      send_byte(DW'(i), 1'b0);
      if (i == 11) check("no_early_word", 128'(out_valid), 128'(1'b0));
    end
    check("full_latency", 128'(out_valid), 128'(1'b1));
    check("full_lane0", 128'(out_data[0]), 128'(8'h01));
    check("full_lane11", 128'(out_data[11]), 128'(8'h0C));
    drain();
    check("full_word_cnt", 128'(word_cnt), 128'(16'd1));

    // Short word closed by in_last.
    for (int i = 0; i < 5; i++) send_byte(DW'(8'hA0 + i), i == 4);
    check("short_count", 128'(out_count), 128'(5));
    check("short_last", 128'(out_last), 128'(1'b1));
    check("short_zero_lanes", 128'(out_data[LANES-1:5]), 128'(0));
    drain();

    // Back-pressure: two words fill the block, one handshake frees it.
    fixed_rdy = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 24; i++) send_byte(DW'(8'h30 + i), 1'b0);
    check("stall_in_ready", 128'(in_ready), 128'(1'b0));
    check("stall_lane0", 128'(out_data[0]), 128'(8'h30));
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check("stall_hold_ready", 128'(in_ready), 128'(1'b0));
    check("stall_hold_lane0", 128'(out_data[0]), 128'(8'h30));
    fixed_rdy = 1'b1;
    @(posedge clk);
    #1;
    fixed_rdy = 1'b0;
    check("release_in_ready", 128'(in_ready), 128'(1'b1));
    check("release_valid", 128'(out_valid), 128'(1'b1));
    check("release_lane0", 128'(out_data[0]), 128'(8'h3C));
    fixed_rdy = 1'b1;
    drain();
    check("stall_word_cnt", 128'(word_cnt), 128'(16'd4));

    // Sustained streaming: 36 bytes in 36 cycles, a word after every 12th.
    t0 = cyc;
    for (int k = 0; k < 36; k++) begin
      send_byte(DW'($urandom), 1'b0);
      if (k % 12 == 11) check("stream_boundary", 128'(out_valid), 128'(1'b1));
    end
    check("stream_cycles", 128'(cyc - t0), 128'(36));
    drain();
    check("stream_word_cnt", 128'(word_cnt), 128'(16'd7));

    // Reset mid-word discards the partial word.
    for (int i = 0; i < 7; i++) send_byte(DW'(8'hE0 + i), 1'b0);
    do_reset();
    for (int i = 0; i < 12; i++) send_byte(DW'(8'h10 + i), 1'b0);
    check("post_reset_lane0", 128'(out_data[0]), 128'(8'h10));
    drain();
    check("post_reset_word_cnt", 128'(word_cnt), 128'(16'd1));

    // Random data, early closes, idle gaps and back-pressure.
    rand_mode = 1'b1;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) begin
          @(posedge clk);
          #1;
        end
      end
      send_byte(DW'($urandom), $urandom_range(0, 7) == 0);
    end
    if (cur_q.size() != 0) send_byte(DW'($urandom), 1'b1);
    drain();
    rand_mode = 1'b0;
    fixed_rdy = 1'b1;

    // word_cnt wrap: 65535 single-byte words, then one more.
    do_reset();
    for (int i = 0; i < 65535; i++) send_byte(DW'(i), 1'b1);
    drain();
    check("wrap_ffff", 128'(word_cnt), 128'(16'hFFFF));
    send_byte(8'h55, 1'b1);
    drain();
    check("wrap_zero", 128'(word_cnt), 128'(16'h0000));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
